mtm_custom_pattern_checker: RTL and testbench

- Streaming sink that checks a received data stream against a software-loaded pattern; receive-side counterpart of mtm_custom_pattern_generator.
- Pattern RAM and CSR map mirror the generator, so both ends are programmed identically.
- Accepts payload_length beats, compares each against the cyclic pattern, and reports a saturating error count, a sticky error flag and the index of the first failing beat.

---
 rtl/mtm_custom_pattern_checker.sv | 167 ++++++++++++++++
 tb/tb_mtm_custom_pattern_checker.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_custom_pattern_checker.sv
// Streaming pattern checker: compares payload_length received beats against a
// software-loaded cyclic pattern and reports error count, sticky error and first-fail index.
module mtm_custom_pattern_checker #(
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_PATTERN_LENGTH = 64,
  parameter int ADDRESS_WIDTH      = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               csr_address,
  input  logic [31:0]              csr_writedata,
  input  logic                     csr_write,
  input  logic [3:0]               csr_byteenable,
  input  logic                     csr_read,
  output logic [31:0]              csr_readdata,
  input  logic [ADDRESS_WIDTH-1:0] pattern_address,
  input  logic [DATA_WIDTH-1:0]    pattern_writedata,
  input  logic                     pattern_write,
  input  logic [DATA_WIDTH/8-1:0]  pattern_byteenable,
  input  logic [DATA_WIDTH-1:0]    snk_data,
  input  logic                     snk_valid,
  output logic                     snk_ready
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_CHECK, S_DRAIN, S_DONE} state_t;
  state_t state, state_next;

  logic [31:0] payload_length, run_payload, beat_cnt, error_count, first_fail, cmp_beat;
  logic [15:0] pattern_position, pattern_length, run_length, idx, idx_inc, len_eff, pos_eff;
  logic        done, error, cmp_valid, cmp_miss;
  logic        ctrl_wr, start, stop, clear, start_ok, running, accept, last_beat;
  logic [DATA_WIDTH-1:0]    ram [MAX_PATTERN_LENGTH];
  logic [DATA_WIDTH-1:0]    expected;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [31:0]              rd_mux;

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wr,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wr[8*b +: 8];
    return r;
  endfunction

  assign ctrl_wr   = csr_write && (csr_address == 2'd2) && csr_byteenable[3];
  assign start     = ctrl_wr && csr_writedata[24];
  assign stop      = ctrl_wr && csr_writedata[25];
  assign clear     = ctrl_wr && csr_writedata[26];
  assign running   = (state == S_PREFETCH) || (state == S_CHECK) || (state == S_DRAIN);
  assign start_ok  = start && !stop && ((state == S_IDLE) || (state == S_DONE));
  assign snk_ready = (state == S_CHECK);
  assign accept    = snk_valid && snk_ready;
  assign last_beat = (beat_cnt == run_payload - 32'd1);
  assign idx_inc   = (idx == run_length - 16'd1) ? '0 : idx + 16'd1;
  assign len_eff   = (pattern_length == '0) ? 16'd1 : pattern_length;
  assign pos_eff   = (pattern_position >= len_eff) ? '0 : pattern_position;
  // Look one word ahead on an accepted beat so the next compare has its word ready.
  assign rd_addr   = accept ? idx_inc[ADDRESS_WIDTH-1:0] : idx[ADDRESS_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (pattern_write)
      for (int unsigned b = 0; b < NBYTES; b++)
        if (pattern_byteenable[b])
          ram[pattern_address][8*b +: 8] <= pattern_writedata[8*b +: 8];
    expected <= ram[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      payload_length   <= '0;
      pattern_position <= '0;
      pattern_length   <= '0;
    end else if (csr_write && !running) begin
      case (csr_address)
        2'd0:    payload_length <= merge32(payload_length, csr_writedata, csr_byteenable);
        2'd1:    {pattern_position, pattern_length} <=
                   merge32({pattern_position, pattern_length}, csr_writedata, csr_byteenable);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start_ok) state_next = S_PREFETCH;
      S_PREFETCH: if (stop) state_next = S_IDLE;
                  else if (run_payload == '0) state_next = S_DONE;
                  else state_next = S_CHECK;
      S_CHECK:    if (stop) state_next = S_IDLE;
                  else if (accept && last_beat) state_next = S_DRAIN;
      S_DRAIN:    state_next = stop ? S_IDLE : S_DONE;
      S_DONE:     state_next = start_ok ? S_PREFETCH : S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_payload <= '0;
      run_length  <= 16'd1;
      idx         <= '0;
      beat_cnt    <= '0;
      error_count <= '0;
      first_fail  <= '0;
      error       <= 1'b0;
      done        <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_miss    <= 1'b0;
      cmp_beat    <= '0;
    end else if (start_ok) begin
      run_payload <= payload_length;
      run_length  <= len_eff;
      idx         <= pos_eff;
      beat_cnt    <= '0;
      error_count <= '0;
      error       <= 1'b0;
      done        <= 1'b0;
      cmp_valid   <= 1'b0;
    end else begin
      cmp_valid <= accept;
      if (accept) begin
        cmp_miss <= (snk_data != expected);
        cmp_beat <= beat_cnt;
        beat_cnt <= beat_cnt + 32'd1;
        idx      <= idx_inc;
      end
      if (cmp_valid && cmp_miss) begin
        if (error_count != '1) error_count <= error_count + 32'd1;
        if (!error) first_fail <= cmp_beat;
        error <= 1'b1;
      end
      if (((state == S_PREFETCH) || (state == S_DRAIN)) && (state_next == S_DONE))
        done <= 1'b1;
      if (clear && !running) begin
        error_count <= '0;
        error       <= 1'b0;
        done        <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      2'd0: rd_mux = payload_length;
      2'd1: rd_mux = (done && error) ? first_fail : {pattern_position, pattern_length};
      2'd2: rd_mux = {29'd0, error, done, running};
      2'd3: rd_mux = error_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csr_readdata <= '0;
    else          csr_readdata <= csr_read ? rd_mux : '0;
  end

endmodule

// File: tb/tb_mtm_custom_pattern_checker.sv
// Randomised self-checking bench for mtm_custom_pattern_checker with a queue-based stream model.
module tb_mtm_custom_pattern_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_address;
  logic [31:0] csr_writedata;
  logic        csr_write;
  logic [3:0]  csr_byteenable;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic [5:0]  pattern_address;
  logic [31:0] pattern_writedata;
  logic        pattern_write;
  logic [3:0]  pattern_byteenable;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;

  int errors = 0;
  int checks = 0;
  int acc_total = 0;
  logic [31:0] ram_m [64];
  logic [31:0] tx [$];

  localparam logic [31:0] CMD_START = 32'h0100_0000;
  localparam logic [31:0] CMD_STOP  = 32'h0200_0000;
  localparam logic [31:0] CMD_CLEAR = 32'h0400_0000;
  localparam logic [31:0] ST_DONE   = 32'h2;
  localparam logic [31:0] ST_ERRDN  = 32'h6;

  mtm_custom_pattern_checker #(
    .DATA_WIDTH(32), .MAX_PATTERN_LENGTH(64), .ADDRESS_WIDTH(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_writedata(csr_writedata), .csr_write(csr_write),
    .csr_byteenable(csr_byteenable), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .pattern_address(pattern_address), .pattern_writedata(pattern_writedata),
    .pattern_write(pattern_write), .pattern_byteenable(pattern_byteenable),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && snk_valid && snk_ready) acc_total++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    csr_address = a; csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic ram_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    pattern_address = a[5:0]; pattern_writedata = d; pattern_byteenable = be; pattern_write = 1'b1;
    tick();
    pattern_write = 1'b0;
    for (int b = 0; b < 4; b++)
      if (be[b]) ram_m[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic configure(input int payload, input int pos, input int len);
    logic [31:0] w;
    w = {pos[15:0], len[15:0]};
    csr_wr(2'd0, payload, 4'hF);
    csr_wr(2'd1, w, 4'hF);
  endtask

  // Expected stream: cyclic walk of the pattern from the effective start position.
  task automatic build_tx(input int payload, input int pos, input int len);
    int l, p0;
    l = (len == 0) ? 1 : len;
    p0 = (pos >= l) ? 0 : pos;
    tx.delete();
    for (int b = 0; b < payload; b++) tx.push_back(ram_m[((p0 + b) % l) % 64]);
  endtask

  task automatic stream(input int first, input int n, input bit toggle, input bit exit_on_n,
                        input int budget, output int acc, output int rdy);
    acc = 0; rdy = 0;
    for (int c = 0; c < budget; c++) begin
      bit a;
      if (exit_on_n && acc == n) break;
      snk_valid = toggle ? (c % 2 == 0) : 1'b1;
      snk_data = (acc < n && first + acc < tx.size()) ? tx[first + acc] : $urandom;
      if (snk_ready) rdy++;
      a = snk_valid && snk_ready;
      tick();
      if (a) acc++;
    end
    snk_valid = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) ram_wr(i, i, 4'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    #1;
    checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", snk_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      csr_rd(a[1:0], d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_csr%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_clean_pass();
    int acc, rdy;
    logic [31:0] d;
    load_ramp();
    configure(32, 0, 8);
    build_tx(32, 0, 8);
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 32, 1'b0, 1'b0, 40, acc, rdy);
    checks++; if (acc !== 32) begin errors++; $display("FAIL clean_beats got=%0d exp=32", acc); end
    checks++; if (rdy !== 32) begin errors++; $display("FAIL clean_ready_cycles got=%0d exp=32", rdy); end
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL clean_status got=%h exp=%h", d, ST_DONE); end
    csr_rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clean_errcnt got=%h exp=0", d); end
    csr_rd(2'd1, d);
    checks++; if (d !== 32'h0000_0008) begin errors++; $display("FAIL clean_cfg1 got=%h exp=00000008", d); end
  endtask

  task automatic test_errors();
    int acc, rdy;
    logic [31:0] d;
    configure(32, 0, 8);
    build_tx(32, 0, 8);
    tx[5] ^= 32'h1;
    tx[20] ^= 32'h1;
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 32, 1'b0, 1'b0, 40, acc, rdy);
    csr_rd(2'd2, d);
    checks++; if (d !== ST_ERRDN) begin errors++; $display("FAIL err_status got=%h exp=%h", d, ST_ERRDN); end
    csr_rd(2'd3, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL err_count got=%0d exp=2", d); end
    csr_rd(2'd1, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL err_first got=%0d exp=5", d); end
    csr_wr(2'd2, CMD_CLEAR, 4'hF);
    csr_rd(2'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status got=%h exp=0", d); end
    csr_rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_count got=%h exp=0", d); end
  endtask

  task automatic test_wrap_backpressure();
    int acc, rdy;
    logic [31:0] d;
    configure(10, 6, 8);
    build_tx(10, 6, 8);
    checks++; if (tx[2] !== 32'd0 || tx[9] !== 32'd7) begin errors++; $display("FAIL wrap_model got=%0d,%0d exp=0,7", tx[2], tx[9]); end
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 9, 1'b1, 1'b1, 40, acc, rdy);
    checks++; if (acc !== 9) begin errors++; $display("FAIL wrap_first9 got=%0d exp=9", acc); end
    csr_rd(2'd2, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL wrap_midstatus got=%h exp=1", d); end
    stream(9, 1, 1'b1, 1'b0, 20, acc, rdy);
    checks++; if (acc !== 1) begin errors++; $display("FAIL wrap_last got=%0d exp=1", acc); end
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL wrap_status got=%h exp=%h", d, ST_DONE); end
    csr_rd(2'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap_errcnt got=%h exp=0", d); end
  endtask

  task automatic test_payload_zero();
    logic [31:0] d;
    int a0;
    bit seen;
    configure(0, 0, 8);
    a0 = acc_total;
    seen = 1'b0;
    snk_valid = 1'b1;
    csr_wr(2'd2, CMD_START, 4'hF);
    for (int i = 0; i < 3 && !seen; i++) begin
      csr_rd(2'd2, d);
      if (d[1]) seen = 1'b1;
    end
    snk_valid = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_done got=%h exp=done", d); end
    checks++; if (acc_total !== a0) begin errors++; $display("FAIL zero_beats got=%0d exp=0", acc_total - a0); end
  endtask

  task automatic test_stop();
    int acc, rdy;
    logic [31:0] d;
    configure(32, 0, 8);
    build_tx(32, 0, 8);
    tx[2] ^= 32'h80;
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 4, 1'b0, 1'b1, 20, acc, rdy);
    csr_wr(2'd2, CMD_STOP, 4'hF);
    checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL stop_ready got=%b exp=0", snk_ready); end
    csr_rd(2'd2, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL stop_status got=%h exp=4", d); end
    csr_rd(2'd3, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL stop_errcnt got=%0d exp=1", d); end
  endtask

  task automatic test_start_while_running();
    int acc, rdy;
    logic [31:0] d;
    configure(16, 0, 8);
    build_tx(16, 0, 8);
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 5, 1'b0, 1'b1, 20, acc, rdy);
    csr_wr(2'd2, CMD_START, 4'hF);
    csr_wr(2'd0, 32'd100, 4'hF);
    stream(5, 11, 1'b0, 1'b0, 30, acc, rdy);
    checks++; if (acc !== 11) begin errors++; $display("FAIL restart_beats got=%0d exp=11", acc); end
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL restart_status got=%h exp=%h", d, ST_DONE); end
    csr_rd(2'd0, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL cfg_locked got=%0d exp=16", d); end
    csr_wr(2'd2, CMD_START | CMD_STOP, 4'hF);
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL startstop_status got=%h exp=%h", d, ST_DONE); end
  endtask

  task automatic test_async_reset();
    int acc, rdy;
    logic [31:0] d;
    configure(32, 0, 8);
    build_tx(32, 0, 8);
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 3, 1'b0, 1'b1, 20, acc, rdy);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (snk_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", snk_ready); end
    @(negedge clk) reset_n = 1'b1;
    tick();
    csr_rd(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arst_payload got=%h exp=0", d); end
    configure(8, 0, 8);
    build_tx(8, 0, 8);
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 8, 1'b0, 1'b0, 20, acc, rdy);
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL arst_ram_kept got=%h exp=%h", d, ST_DONE); end
  endtask

  task automatic test_byteenable();
    int acc, rdy;
    logic [31:0] d;
    csr_wr(2'd0, 32'h0, 4'hF);
    csr_wr(2'd0, 32'h1234_5678, 4'b0011);
    csr_rd(2'd0, d);
    checks++; if (d !== 32'h0000_5678) begin errors++; $display("FAIL be_csr got=%h exp=00005678", d); end
    tick();
    checks++; if (csr_readdata !== 32'h0) begin errors++; $display("FAIL rd_idle got=%h exp=0", csr_readdata); end
    ram_wr(3, 32'hAABB_CCDD, 4'hF);
    ram_wr(3, 32'h1122_3344, 4'b0001);
    configure(1, 3, 4);
    tx.delete();
    tx.push_back(32'hAABB_CC44);
    csr_wr(2'd2, CMD_START, 4'hF);
    stream(0, 1, 1'b0, 1'b0, 10, acc, rdy);
    csr_rd(2'd2, d);
    checks++; if (d !== ST_DONE) begin errors++; $display("FAIL be_ram got=%h exp=%h", d, ST_DONE); end
  endtask

  task automatic test_random();
    int acc, rdy, payload, pos, len, n_err, first;
    bit tog;
    logic [31:0] d, st;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) ram_wr(i, $urandom, 4'hF);
      len = $urandom_range(0, 12);
      pos = $urandom_range(0, 15);
      payload = $urandom_range(1, 30);
      tog = $urandom_range(0, 1);
      build_tx(payload, pos, len);
      n_err = 0; first = -1;
      for (int b = 0; b < payload; b++)
        if ($urandom_range(0, 3) == 0) begin
          tx[b] ^= (32'h1 << $urandom_range(0, 31));
          n_err++;
          if (first < 0) first = b;
        end
      configure(payload, pos, len);
      csr_wr(2'd2, CMD_START, 4'hF);
      stream(0, payload, tog, 1'b0, 2 * payload + 10, acc, rdy);
      checks++; if (acc !== payload) begin errors++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", it, acc, payload); end
      st = (n_err > 0) ? ST_ERRDN : ST_DONE;
      csr_rd(2'd2, d);
      checks++; if (d !== st) begin errors++; $display("FAIL rnd%0d_status got=%h exp=%h", it, d, st); end
      csr_rd(2'd3, d);
      checks++; if (d !== n_err) begin errors++; $display("FAIL rnd%0d_errcnt got=%0d exp=%0d", it, d, n_err); end
      if (n_err > 0) begin
        csr_rd(2'd1, d);
        checks++; if (d !== first) begin errors++; $display("FAIL rnd%0d_first got=%0d exp=%0d", it, d, first); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    csr_address = '0; csr_writedata = '0; csr_write = 1'b0; csr_byteenable = '0; csr_read = 1'b0;
    pattern_address = '0; pattern_writedata = '0; pattern_write = 1'b0; pattern_byteenable = '0;
    snk_data = '0; snk_valid = 1'b0;
    for (int i = 0; i < 64; i++) ram_m[i] = '0;
    test_reset();
    test_clean_pass();
    test_errors();
    test_wrap_backpressure();
    test_payload_zero();
    test_stop();
    test_start_while_running();
    test_async_reset();
    test_byteenable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
